// File: rtl/ext_irq_pkg.sv
// rtl/ext_irq_pkg.sv - shared constants and types for the external interrupt controller
package ext_irq_pkg;

    localparam int ID_W = 5;

    localparam logic [7:0] PRIO_BASE   = 8'h00;
    localparam logic [7:0] PENDING_OFF = 8'h40;
    localparam logic [7:0] ENABLE_OFF  = 8'h44;
    localparam logic [7:0] THRESH_OFF  = 8'h48;
    localparam logic [7:0] CLAIM_OFF   = 8'h4C;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PEND     = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// rtl/irq_gateway.sv - per-source synchronizer and claim/complete gateway
module irq_gateway
    import ext_irq_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic irq_in,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    logic      sync1_q, sync1_d;
    logic      sync2_q, sync2_d;
    gw_state_e state_q, state_d;

    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
        state_d = state_q;
        case (state_q)
            GW_IDLE:     if (sync2_q)  state_d = GW_PEND;
            GW_PEND:     if (claim)    state_d = GW_INFLIGHT;
            GW_INFLIGHT: if (complete) state_d = GW_IDLE;
            default:                   state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= GW_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
        end
    end

    assign pending = (state_q == GW_PEND);

endmodule

// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - external interrupt controller: config registers, arbiter, claim/complete window
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         addr,
    input  logic               ren,
    input  logic               wen,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    output logic               external_interrupt
);

    // index i holds source ID i+1
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0]             enable_q, enable_d;
    logic [PRIO_W-1:0]              thresh_q, thresh_d;
    logic [31:0]                    rd_q, rd_d;
    logic                           ext_irq_q, ext_irq_d;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] claim;
    logic [NUM_SRC-1:0] complete;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic [5:0]         word;
    logic               claim_rd;
    logic               complete_wr;
    logic [31:0]        rd_word;
    logic               unused_addr_bits;

    assign word             = addr[7:2];
    assign unused_addr_bits = ^addr[1:0];
    assign claim_rd         = ren && (word == CLAIM_OFF[7:2]);
    assign complete_wr      = wen && (word == CLAIM_OFF[7:2]);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clock    (clock),
            .reset    (reset),
            .irq_in   (irq_src[g]),
            .claim    (claim[g]),
            .complete (complete[g]),
            .pending  (pending[g])
        );
    end

    // Seeding with the threshold enforces prio > threshold; strict > keeps the lowest ID on ties.
    always_comb begin
        win_id   = '0;
        win_prio = thresh_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable_q[i] && (prio_q[i] > win_prio)) begin
                win_id   = ID_W'(i + 1);
                win_prio = prio_q[i];
            end
        end
    end

    always_comb begin
        claim    = '0;
        complete = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim[i]    = claim_rd && (win_id == ID_W'(i + 1));
            complete[i] = complete_wr && (wd[ID_W-1:0] == ID_W'(i + 1));
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (word == PRIO_BASE[7:2] + 6'(i)) rd_word = 32'(prio_q[i]);
        end
        case (word)
            PENDING_OFF[7:2]: rd_word = 32'({pending, 1'b0});
            ENABLE_OFF[7:2]:  rd_word = 32'({enable_q, 1'b0});
            THRESH_OFF[7:2]:  rd_word = 32'(thresh_q);
            CLAIM_OFF[7:2]:   rd_word = 32'(win_id);
            default:          ;
        endcase
    end

    always_comb begin
        prio_d    = prio_q;
        enable_d  = enable_q;
        thresh_d  = thresh_q;
        rd_d      = rd_q;
        ext_irq_d = (win_id != '0);
        if (wen) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (word == PRIO_BASE[7:2] + 6'(i)) prio_d[i] = wd[PRIO_W-1:0];
            end
            if (word == ENABLE_OFF[7:2]) enable_d = wd[NUM_SRC:1];
            if (word == THRESH_OFF[7:2]) thresh_d = wd[PRIO_W-1:0];
        end
        if (ren) rd_d = (wen && !claim_rd) ? wd : rd_word;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_q    <= '0;
            enable_q  <= '0;
            thresh_q  <= '0;
            rd_q      <= '0;
            ext_irq_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            thresh_q  <= thresh_d;
            rd_q      <= rd_d;
            ext_irq_q <= ext_irq_d;
        end
    end

    assign rd                 = rd_q;
    assign external_interrupt = ext_irq_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb/tb_ext_irq_ctrl.sv - self-checking bench for ext_irq_ctrl
module tb_ext_irq_ctrl;

    localparam int NSRC = 8;
    localparam int PW   = 3;

    logic            clock   = 1'b0;
    logic            rst_n   = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic [7:0]      addr    = '0;
    logic            ren     = 1'b0;
    logic            wen     = 1'b0;
    logic [31:0]     wd      = '0;
    logic [31:0]     rd;
    logic            ext;

    ext_irq_ctrl #(.NUM_SRC(NSRC), .PRIO_W(PW)) dut (
        .clock              (clock),
        .reset              (rst_n),
        .irq_src            (irq_src),
        .addr               (addr),
        .ren                (ren),
        .wen                (wen),
        .wd                 (wd),
        .rd                 (rd),
        .external_interrupt (ext)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: per-source sets plus a two-deep history of the raw lines
    int          m_prio [1:NSRC];
    bit          m_en   [1:NSRC];
    int          m_th;
    bit          m_pend [1:NSRC];
    bit          m_infl [1:NSRC];
    bit          m_s1   [1:NSRC];
    bit          m_s2   [1:NSRC];
    logic [31:0] m_rd;
    bit          m_ext;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int id = 1; id <= NSRC; id++) begin
            m_prio[id] = 0; m_en[id] = 0; m_pend[id] = 0;
            m_infl[id] = 0; m_s1[id] = 0; m_s2[id] = 0;
        end
        m_th  = 0;
        m_rd  = '0;
        m_ext = 0;
    endtask

    // best = highest priority, then lowest ID, folded into one score
    function automatic int m_winner();
        int best  = 0;
        int score = -1;
        for (int id = 1; id <= NSRC; id++) begin
            if (m_pend[id] && m_en[id] && m_prio[id] > m_th && (m_prio[id] * 64 - id) > score) begin
                best  = id;
                score = m_prio[id] * 64 - id;
            end
        end
        return best;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a, input bit w, input logic [31:0] d, input int win);
        int          wi = int'(a[7:2]);
        logic [31:0] v  = '0;
        if (w && wi != 19) return d;
        if (wi < 16) begin
            if (wi + 1 <= NSRC) v = 32'(m_prio[wi + 1]);
        end else if (wi == 16) begin
            for (int id = 1; id <= NSRC; id++) v[id] = m_pend[id];
        end else if (wi == 17) begin
            for (int id = 1; id <= NSRC; id++) v[id] = m_en[id];
        end else if (wi == 18) begin
            v = 32'(m_th);
        end else if (wi == 19) begin
            v = 32'(win);
        end
        return v;
    endfunction

    task automatic cycle(input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
        int win;
        int wi;
        int cid;
        bit idle_pre [1:NSRC];
        bit infl_pre [1:NSRC];
        ren = r; wen = w; addr = a; wd = d;
        wi  = int'(a[7:2]);
        win = m_winner();
        if (r) m_rd = model_read(a, w, d, win);
        for (int id = 1; id <= NSRC; id++) begin
            idle_pre[id] = !m_pend[id] && !m_infl[id];
            infl_pre[id] = m_infl[id];
        end
        if (w && wi == 19) begin
            cid = int'(d[4:0]);
            if (cid >= 1 && cid <= NSRC && infl_pre[cid]) m_infl[cid] = 0;
        end
        if (r && wi == 19 && win != 0) begin
            m_pend[win] = 0;
            m_infl[win] = 1;
        end
        for (int id = 1; id <= NSRC; id++) begin
            if (idle_pre[id] && m_s2[id]) m_pend[id] = 1;
            m_s2[id] = m_s1[id];
            m_s1[id] = irq_src[id-1];
        end
        if (w) begin
            if (wi < 16 && wi + 1 <= NSRC) m_prio[wi + 1] = int'(d[PW-1:0]);
            if (wi == 17) for (int id = 1; id <= NSRC; id++) m_en[id] = d[id];
            if (wi == 18) m_th = int'(d[PW-1:0]);
        end
        m_ext = (win != 0);
        @(posedge clock);
        #1;
        ren = 1'b0;
        wen = 1'b0;
        chk("ext_vs_model", 32'(ext), 32'(m_ext));
        chk("rd_vs_model", rd, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 32'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle(0, 1, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        cycle(1, 0, a, 32'h0);
        chk(name, rd, exp);
    endtask

    typedef struct {
        bit              r;
        bit              w;
        logic [7:0]      a;
        logic [31:0]     d;
        logic [NSRC-1:0] irq;
        logic [31:0]     exp_rd;
        bit              exp_ext;
    } tv_t;

    tv_t tv [14];

    initial begin
        logic [7:0]  ra;
        logic [31:0] rdv;
        int          sel;

        tv[0]  = '{0, 1, 8'h08, 32'd2,    8'h00, 32'h0,  0};
        tv[1]  = '{0, 1, 8'h44, 32'h08,   8'h00, 32'h0,  0};
        tv[2]  = '{0, 1, 8'h48, 32'h0,    8'h00, 32'h0,  0};
        tv[3]  = '{0, 0, 8'h00, 32'h0,    8'h04, 32'h0,  0};
        tv[4]  = '{0, 0, 8'h00, 32'h0,    8'h00, 32'h0,  0};
        tv[5]  = '{0, 0, 8'h00, 32'h0,    8'h00, 32'h0,  0};
        tv[6]  = '{0, 0, 8'h00, 32'h0,    8'h00, 32'h0,  1};
        tv[7]  = '{1, 0, 8'h40, 32'h0,    8'h00, 32'h08, 1};
        tv[8]  = '{1, 0, 8'h4C, 32'h0,    8'h00, 32'd3,  1};
        tv[9]  = '{0, 0, 8'h00, 32'h0,    8'h00, 32'h0,  0};
        tv[10] = '{1, 0, 8'h40, 32'h0,    8'h00, 32'h0,  0};
        tv[11] = '{0, 1, 8'h4C, 32'd3,    8'h00, 32'h0,  0};
        tv[12] = '{1, 0, 8'h08, 32'h0,    8'h00, 32'd2,  0};
        tv[13] = '{1, 0, 8'h4C, 32'h0,    8'h00, 32'h0,  0};

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rd", rd, 32'h0);
        chk("reset_ext", 32'(ext), 32'h0);
        rst_n = 1'b1;
        rd_chk("reset_prio3", 8'h08, 32'h0);
        rd_chk("reset_pending", 8'h40, 32'h0);
        rd_chk("reset_enable", 8'h44, 32'h0);
        rd_chk("reset_thresh", 8'h48, 32'h0);
        rd_chk("reset_claim", 8'h4C, 32'h0);

        // single source, table-driven
        for (int i = 0; i < 14; i++) begin
            irq_src = tv[i].irq;
            cycle(tv[i].r, tv[i].w, tv[i].a, tv[i].d);
            chk("tbl_ext", 32'(ext), 32'(tv[i].exp_ext));
            if (tv[i].r) chk("tbl_rd", rd, tv[i].exp_rd);
        end

        // priority and tie-break
        wr(8'h00, 4); wr(8'h10, 4); wr(8'h04, 6); wr(8'h44, 32'h26);
        irq_src = 8'b0001_0011; idle(1); irq_src = '0; idle(3);
        chk("tie_ext", 32'(ext), 32'h1);
        rd_chk("tie_claim1", 8'h4C, 32'd2); wr(8'h4C, 2);
        rd_chk("tie_claim2", 8'h4C, 32'd1); wr(8'h4C, 1);
        rd_chk("tie_claim3", 8'h4C, 32'd5); wr(8'h4C, 5);
        rd_chk("tie_claim4", 8'h4C, 32'd0);

        // threshold
        wr(8'h0C, 3); wr(8'h44, 32'h10); wr(8'h48, 3);
        irq_src[3] = 1'b1; idle(5);
        chk("thr_blocked", 32'(ext), 32'h0);
        rd_chk("thr_pending", 8'h40, 32'h10);
        wr(8'h48, 2);
        chk("thr_same_edge", 32'(ext), 32'h0);
        idle(1);
        chk("thr_next_edge", 32'(ext), 32'h1);
        irq_src = '0;
        rd_chk("thr_claim", 8'h4C, 32'd4); wr(8'h4C, 4); wr(8'h48, 0);

        // level held re-pends after completion; stray complete ignored
        wr(8'h00, 5); wr(8'h44, 32'h02);
        irq_src[0] = 1'b1; idle(4);
        chk("lvl_ext", 32'(ext), 32'h1);
        rd_chk("lvl_claim", 8'h4C, 32'd1);
        idle(1);
        chk("lvl_ext_drop", 32'(ext), 32'h0);
        wr(8'h4C, 1); idle(2);
        chk("lvl_ext_back", 32'(ext), 32'h1);
        rd_chk("lvl_pend_before", 8'h40, 32'h02);
        wr(8'h4C, 6);
        rd_chk("lvl_pend_after", 8'h40, 32'h02);
        irq_src = '0;
        rd_chk("lvl_claim2", 8'h4C, 32'd1); wr(8'h4C, 1); idle(3);

        // claim and complete in one cycle
        wr(8'h04, 3); wr(8'h18, 5); wr(8'h44, 32'h84);
        irq_src[1] = 1'b1; idle(1); irq_src = '0; idle(3);
        rd_chk("sc_claim2", 8'h4C, 32'd2);
        irq_src[6] = 1'b1; idle(4);
        cycle(1, 1, 8'h4C, 32'd2);
        chk("sc_rd", rd, 32'd7);
        idle(3);
        rd_chk("sc_pend_none", 8'h40, 32'h0);
        irq_src[1] = 1'b1; idle(1); irq_src[1] = 1'b0; idle(3);
        rd_chk("sc_src2_idle", 8'h40, 32'h04);
        wr(8'h4C, 7); idle(3);
        rd_chk("sc_src7_done", 8'h40, 32'h84);
        irq_src = '0;
        rd_chk("sc_claim7", 8'h4C, 32'd7); wr(8'h4C, 7);
        rd_chk("sc_claim2b", 8'h4C, 32'd2); wr(8'h4C, 2);

        // reset mid-operation
        wr(8'h08, 2); wr(8'h10, 1); wr(8'h44, 32'h28);
        irq_src = 8'b0001_0100; idle(1); irq_src = '0; idle(3);
        rd_chk("rst_claim", 8'h4C, 32'd3);
        idle(1);
        chk("rst_ext_before", 32'(ext), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_now", rd, 32'h0);
        chk("rst_ext_now", 32'(ext), 32'h0);
        model_reset();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        rd_chk("rst_prio3", 8'h08, 32'h0);
        rd_chk("rst_enable", 8'h44, 32'h0);
        rd_chk("rst_thresh", 8'h48, 32'h0);
        rd_chk("rst_pending", 8'h40, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) irq_src[$urandom_range(0, NSRC-1)] ^= 1'b1;
            sel = int'($urandom_range(0, 9));
            ra  = 8'($urandom_range(0, 255));
            rdv = $urandom;
            case (sel)
                3: cycle(1, 0, 8'h4C, 32'h0);
                4: wr(8'h4C, 32'($urandom_range(0, 10)));
                5: wr({2'b00, ra[5:0]}, rdv);
                6: wr(8'h44, rdv);
                7: wr(8'h48, 32'($urandom_range(0, 3)));
                8: cycle(1, 0, (ra[0] ? {2'b01, 3'b000, ra[3:1]} : ra), 32'h0);
                9: cycle(1, 1, {2'b00, ra[5:0]}, rdv);
                default: idle(1);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
